// File: rtl/uart_byte_transmitter.sv
// 8N1 UART byte transmitter, LSB first, idle-high line.
// A rising edge on tx_start while idle latches tx_data and sends one 10-slot frame.
module uart_byte_transmitter #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_state,
  output logic       rs232_tx
);

  // Clocks per bit slot; must stay within 2..65535 to fit the 16-bit baud counter.
  localparam int         BPS       = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BAUD_LAST = 16'(BPS - 1);
  localparam logic [3:0]  LAST_SLOT = 4'd9;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e      state_q, state_d;
  logic        tx_start_q;
  logic [7:0]  data_q, data_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic        line_q, line_d;
  logic        done_q, done_d;
  logic        start_edge;

  assign start_edge = tx_start & ~tx_start_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      data_q     <= 8'd0;
      baud_q     <= 16'd0;
      bit_q      <= 4'd0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start;
      data_q     <= data_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      line_q     <= line_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    line_d  = line_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        bit_d  = 4'd0;
        line_d = 1'b1;
        if (start_edge) begin
          state_d = SEND;
          data_d  = tx_data;
          line_d  = 1'b0;
        end
      end
      SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = 16'd0;
          if (bit_q == LAST_SLOT) begin
            state_d = IDLE;
            bit_d   = 4'd0;
            line_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            // Slot bit_q+1 carries data bit bit_q; slot 9 is the stop bit.
            bit_d  = bit_q + 4'd1;
            line_d = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_state = (state_q == SEND);
  assign tx_done  = done_q;
  assign rs232_tx = line_q;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Self-checking bench for uart_byte_transmitter: frame vectors, corner sequences,
// and random start/data traffic compared every cycle against a timestamp-based model.
module tb_uart_byte_transmitter;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 62;
  localparam int BPS       = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = 10 * BPS;

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'd0;
  logic       tx_done;
  logic       tx_state;
  logic       rs232_tx;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  uart_byte_transmitter #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .tx_state(tx_state),
    .rs232_tx(rs232_tx)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] data;
    logic       changeData;
    logic [7:0] newData;
    logic [9:0] expBits;
  } vec_t;

  vec_t vecs[5];

  // Reference model: remembers when the current frame was accepted and derives the line from elapsed time.
  longint     cyc     = 0;
  longint     mStart  = 0;
  bit         mActive = 1'b0;
  bit         mDone   = 1'b0;
  bit         mPrev   = 1'b0;
  bit         wasActive;
  logic [7:0] mData   = 8'd0;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mActive = 1'b0;
      mDone   = 1'b0;
      mPrev   = 1'b0;
    end else begin
      cyc++;
      mDone     = 1'b0;
      wasActive = mActive;
      if (mActive && (cyc - mStart) == FRAME) begin
        mActive = 1'b0;
        mDone   = 1'b1;
      end
      if (!wasActive && tx_start && !mPrev) begin
        mActive = 1'b1;
        mStart  = cyc;
        mData   = tx_data;
      end
      mPrev = tx_start;
    end
  end

  function automatic logic expLine();
    int slot;
    if (!mActive) return 1'b1;
    slot = int'((cyc - mStart) / BPS);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return mData[slot-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (checkEn)
      checkOutput("cycleModel", {29'd0, rs232_tx, tx_state, tx_done}, {29'd0, expLine(), mActive, mDone});
  end

  // Sends one table vector and inspects the frame sampled mid-slot.
  task automatic applyStimulus(input vec_t v);
    logic [9:0] captured;
    int highCnt, doneCnt, doneAt;
    captured = 10'd0;
    highCnt  = 0;
    doneCnt  = 0;
    doneAt   = -1;
    @(negedge clk_in);
    tx_data  = v.data;
    tx_start = 1'b1;
    @(negedge clk_in);
    tx_start = 1'b0;
    if (v.changeData) tx_data = v.newData;
    for (int i = 0; i < FRAME + 8; i++) begin
      if (i > 0) @(negedge clk_in);
      if (i < FRAME && (i % BPS) == BPS / 2) captured[i / BPS] = rs232_tx;
      if (tx_state) highCnt++;
      if (tx_done) begin
        doneCnt++;
        doneAt = i;
      end
    end
    checkOutput("frameBits", {22'd0, captured}, {22'd0, v.expBits});
    checkOutput("stateLength", highCnt, FRAME);
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("doneTiming", doneAt, FRAME);
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 10 && !seen; i++) begin
      @(negedge clk_in);
      if (tx_done) seen = 1'b1;
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int dones, rises;
    logic prevState;
    bit doneSeen;

    vecs[0] = '{8'h55, 1'b0, 8'h00, 10'b1010101010};
    vecs[1] = '{8'h01, 1'b1, 8'hFF, 10'b1000000010};
    vecs[2] = '{8'hA3, 1'b0, 8'h00, 10'b1101000110};
    vecs[3] = '{8'h00, 1'b1, 8'hFF, 10'b1000000000};
    vecs[4] = '{8'hFF, 1'b1, 8'h00, 10'b1111111110};

    repeat (3) @(negedge clk_in);
    checkEn = 1'b1;
    checkOutput("resetLine", {31'd0, rs232_tx}, 32'd1);
    checkOutput("resetState", {31'd0, tx_state}, 32'd0);
    checkOutput("resetDone", {31'd0, tx_done}, 32'd0);
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    checkOutput("idleHold", {29'd0, rs232_tx, tx_state, tx_done}, 32'b100);

    for (int k = 0; k < 5; k++) applyStimulus(vecs[k]);

    // Level held high across three frame times starts exactly one frame.
    $display("[TB] hold-high sequence");
    dones = 0;
    rises = 0;
    prevState = tx_state;
    @(negedge clk_in);
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk_in);
      if (tx_done) dones++;
      if (tx_state && !prevState) rises++;
      prevState = tx_state;
    end
    checkOutput("holdDones", dones, 1);
    checkOutput("holdFrames", rises, 1);
    tx_start = 1'b0;
    @(negedge clk_in);
    tx_start = 1'b1;
    @(negedge clk_in);
    checkOutput("retrigger", {30'd0, tx_state, rs232_tx}, 32'b10);
    tx_start = 1'b0;
    waitDone("retriggerDone");

    // Mid-frame edge is dropped; an edge two cycles after tx_done starts at once.
    $display("[TB] mid-frame and back-to-back sequence");
    @(negedge clk_in);
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk_in);
    tx_start = 1'b0;
    repeat (50) @(negedge clk_in);
    tx_start = 1'b1;
    @(negedge clk_in);
    tx_start = 1'b0;
    waitDone("midFrameDone");
    @(negedge clk_in);
    checkOutput("dropEdge", {31'd0, tx_state}, 32'd0);
    @(negedge clk_in);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk_in);
    tx_start = 1'b0;
    checkOutput("backToBack", {30'd0, tx_state, rs232_tx}, 32'b10);
    waitDone("backToBackDone");

    // Reset during data bit 4 aborts the frame without tx_done.
    $display("[TB] reset mid-frame sequence");
    @(negedge clk_in);
    tx_data  = 8'h96;
    tx_start = 1'b1;
    @(negedge clk_in);
    tx_start = 1'b0;
    repeat (5 * BPS + 3) @(negedge clk_in);
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("abortLine", {31'd0, rs232_tx}, 32'd1);
    checkOutput("abortState", {31'd0, tx_state}, 32'd0);
    checkOutput("abortDone", {31'd0, tx_done}, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    doneSeen = 1'b0;
    repeat (FRAME) begin
      @(negedge clk_in);
      if (tx_done || tx_state) doneSeen = 1'b1;
    end
    checkOutput("noDoneAfterAbort", {31'd0, doneSeen}, 32'd0);
    applyStimulus(vecs[2]);

    $display("[TB] random traffic");
    repeat (3000) begin
      @(negedge clk_in);
      tx_start = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
    end
    tx_start = 1'b0;
    repeat (FRAME + 5) @(negedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
